// File: rtl/id_stage_pkg.sv
// cpu_defs: shared RV32I definitions for the decode stage.
//   - base opcode constants
//   - immediate-format selector used between decode and imm_gen
//   - default datapath width
package cpu_defs;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: ID/EX pipeline register bundle plus its valid/ready handshake.
//   master (id_stage): drives ex_valid_o and the decoded bundle, samples ex_ready_i.
//   slave  (EX stage): samples the bundle, drives ex_ready_i.
interface id_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid_o;
  logic              ex_ready_i;
  logic [2:0]        aluop_o;
  logic [6:0]        alusel_o;
  logic              alu_alt_o;
  logic [XLEN-1:0]   reg1_o;
  logic [XLEN-1:0]   reg2_o;
  logic [XLEN-1:0]   imm_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic              is_load_o;
  logic              is_store_o;
  logic              illegal_o;
  logic [XLEN-1:0]   pc_o;

  modport master (
    output ex_valid_o, aluop_o, alusel_o, alu_alt_o, reg1_o, reg2_o, imm_o,
           wd_o, wreg_o, is_load_o, is_store_o, illegal_o, pc_o,
    input  ex_ready_i
  );

  modport slave (
    input  ex_valid_o, aluop_o, alusel_o, alu_alt_o, reg1_o, reg2_o, imm_o,
           wd_o, wreg_o, is_load_o, is_store_o, illegal_o, pc_o,
    output ex_ready_i
  );
endinterface

// File: rtl/id_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
//   inst : instruction bits [31:7] (opcode bits carry no immediate data)
//   fmt  : immediate format chosen by decode
//   imm  : immediate sign-extended to XLEN (0 for IMM_NONE)
module imm_gen
  import cpu_defs::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:7]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed width cast carries bit 31 out to the full datapath width.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// id_stage: pipelined RV32I instruction decode.
//   clk, rst          : clock, async active-high reset
//   flush_i           : drop the instruction in ID and invalidate ID/EX
//   if_valid_i/if_ready_o, pc_i, inst_i : IF/ID handshake and instruction
//   reg*_read_o/addr_o/data_i           : combinational register-file read
//   ex_*/mem_*        : writeback info from EX and MEM for forwarding/hazards
//   ex                : ID/EX output register bundle and handshake
module id_stage
  import cpu_defs::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [XLEN-1:0]   reg1_data_i,
  input  logic [XLEN-1:0]   reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  id_stage_if.master        ex
);

  localparam logic FWD = (FWD_EN != 0);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  imm_fmt_e        fmt;
  logic            legal;
  logic            writes;
  logic            alt;
  logic            wreg_d;
  logic [XLEN-1:0] imm_d;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign rd     = inst_i[11:7];

  always_comb begin
    fmt         = IMM_NONE;
    legal       = 1'b1;
    writes      = 1'b1;
    alt         = 1'b0;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: fmt = IMM_U;
      OPC_JAL:            fmt = IMM_J;
      OPC_JALR, OPC_LOAD: begin
        fmt         = IMM_I;
        reg1_read_o = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt         = IMM_I;
        reg1_read_o = 1'b1;
        // Only SLLI/SRLI/SRAI use bit 30 as an ALU modifier; elsewhere it is immediate data.
        alt         = (funct3 == 3'b001 || funct3 == 3'b101) ? inst_i[30] : 1'b0;
      end
      OPC_STORE: begin
        fmt         = IMM_S;
        writes      = 1'b0;
        reg1_read_o = 1'b1;
        reg2_read_o = 1'b1;
      end
      OPC_BRANCH: begin
        fmt         = IMM_B;
        writes      = 1'b0;
        reg1_read_o = 1'b1;
        reg2_read_o = 1'b1;
      end
      OPC_OP: begin
        reg1_read_o = 1'b1;
        reg2_read_o = 1'b1;
        alt         = inst_i[30];
      end
      default: begin
        legal  = 1'b0;
        writes = 1'b0;
      end
    endcase
  end

  assign wreg_d      = writes & (rd != 5'd0);
  assign reg1_addr_o = REG_AW'(inst_i[19:15]);
  assign reg2_addr_o = REG_AW'(inst_i[24:20]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst_i[31:7]),
    .fmt  (fmt),
    .imm  (imm_d)
  );

  // A source is live only when read and not x0; x0 never forwards or stalls.
  logic            src1_live, src2_live;
  logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic            hazard, load_en;
  logic [XLEN-1:0] op1, op2;

  assign src1_live = reg1_read_o & (reg1_addr_o != '0);
  assign src2_live = reg2_read_o & (reg2_addr_o != '0);
  assign ex_hit1   = ex_wreg_i  & (ex_wd_i  == reg1_addr_o);
  assign ex_hit2   = ex_wreg_i  & (ex_wd_i  == reg2_addr_o);
  assign mem_hit1  = mem_wreg_i & (mem_wd_i == reg1_addr_o);
  assign mem_hit2  = mem_wreg_i & (mem_wd_i == reg2_addr_o);

  // With forwarding only a load in EX is unresolvable; without it any pending write is.
  assign hazard = FWD ? (ex_is_load_i & ((src1_live & ex_hit1) | (src2_live & ex_hit2)))
                      : ((src1_live & (ex_hit1 | mem_hit1)) | (src2_live & (ex_hit2 | mem_hit2)));

  assign op1 = !src1_live                        ? '0          :
               (FWD & ex_hit1 & !ex_is_load_i)   ? ex_wdata_i  :
               (FWD & mem_hit1)                  ? mem_wdata_i : reg1_data_i;
  assign op2 = !src2_live                        ? '0          :
               (FWD & ex_hit2 & !ex_is_load_i)   ? ex_wdata_i  :
               (FWD & mem_hit2)                  ? mem_wdata_i : reg2_data_i;

  assign load_en    = !ex.ex_valid_o | ex.ex_ready_i;
  assign if_ready_o = flush_i | (load_en & !hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex.ex_valid_o <= 1'b0;
      ex.aluop_o    <= '0;
      ex.alusel_o   <= '0;
      ex.alu_alt_o  <= 1'b0;
      ex.reg1_o     <= '0;
      ex.reg2_o     <= '0;
      ex.imm_o      <= '0;
      ex.wd_o       <= '0;
      ex.wreg_o     <= 1'b0;
      ex.is_load_o  <= 1'b0;
      ex.is_store_o <= 1'b0;
      ex.illegal_o  <= 1'b0;
      ex.pc_o       <= '0;
    end else if (flush_i) begin
      ex.ex_valid_o <= 1'b0;
    end else if (load_en) begin
      // A hazard loads a bubble; the instruction stays in IF/ID for retry.
      ex.ex_valid_o <= if_valid_i & !hazard;
      ex.aluop_o    <= funct3;
      ex.alusel_o   <= opcode;
      ex.alu_alt_o  <= alt;
      ex.reg1_o     <= op1;
      ex.reg2_o     <= op2;
      ex.imm_o      <= imm_d;
      ex.wd_o       <= REG_AW'(rd);
      ex.wreg_o     <= wreg_d;
      ex.is_load_o  <= (opcode == OPC_LOAD);
      ex.is_store_o <= (opcode == OPC_STORE);
      ex.illegal_o  <= !legal;
      ex.pc_o       <= pc_i;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage. Two instances share all inputs,
// one with forwarding and one without, and are checked against a bench model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, ex_ready;
  logic [31:0] pc, inst, reg1_data, reg2_data, ex_wdata, mem_wdata;
  logic        ex_wreg, ex_is_load, mem_wreg;
  logic [4:0]  ex_wd, mem_wd;

  logic        if_ready1, rd1_1, rd2_1, if_ready0, rd1_0, rd2_0;
  logic [4:0]  ad1_1, ad2_1, ad1_0, ad2_0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32), .REG_AW(5)) if1 ();
  id_stage_if #(.XLEN(32), .REG_AW(5)) if0 ();
  assign if1.ex_ready_i = ex_ready;
  assign if0.ex_ready_i = ex_ready;

  id_stage #(.XLEN(32), .REG_AW(5), .FWD_EN(1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready1),
    .pc_i(pc), .inst_i(inst), .reg1_read_o(rd1_1), .reg2_read_o(rd2_1),
    .reg1_addr_o(ad1_1), .reg2_addr_o(ad2_1), .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_wreg_i(ex_wreg), .ex_is_load_i(ex_is_load), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata), .ex(if1));

  id_stage #(.XLEN(32), .REG_AW(5), .FWD_EN(0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready0),
    .pc_i(pc), .inst_i(inst), .reg1_read_o(rd1_0), .reg2_read_o(rd2_0),
    .reg1_addr_o(ad1_0), .reg2_addr_o(ad2_0), .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_wreg_i(ex_wreg), .ex_is_load_i(ex_is_load), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata), .ex(if0));

  typedef struct packed {
    logic        valid;
    logic [2:0]  aluop;
    logic [6:0]  alusel;
    logic        alt;
    logic [31:0] r1, r2, imm;
    logic [4:0]  wd;
    logic        wreg, ld, st, ill;
    logic [31:0] pc;
  } bundle_t;

  typedef struct packed {
    logic        legal, rd1, rd2, wr, alt;
    logic [31:0] imm;
  } dec_t;

  bundle_t m1 = '0, m0 = '0, a1, a0;

  assign a1 = {if1.ex_valid_o, if1.aluop_o, if1.alusel_o, if1.alu_alt_o, if1.reg1_o, if1.reg2_o,
               if1.imm_o, if1.wd_o, if1.wreg_o, if1.is_load_o, if1.is_store_o, if1.illegal_o, if1.pc_o};
  assign a0 = {if0.ex_valid_o, if0.aluop_o, if0.alusel_o, if0.alu_alt_o, if0.reg1_o, if0.reg2_o,
               if0.imm_o, if0.wd_o, if0.wreg_o, if0.is_load_o, if0.is_store_o, if0.illegal_o, if0.pc_o};

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Immediates built from field arithmetic; sign handled by subtracting 2^width.
  function automatic dec_t mdec(logic [31:0] i);
    dec_t        d;
    logic [31:0] u;
    logic [31:0] f3;
    d       = '0;
    d.legal = 1'b1;
    u       = 32'h0;
    f3      = (i >> 12) & 32'h7;
    case (i & 32'h7F)
      32'h37, 32'h17: begin d.wr = 1'b1; u = i & 32'hFFFF_F000; end
      32'h6F: begin
        d.wr = 1'b1;
        u = ((i >> 31) << 20) | (((i >> 12) & 32'hFF) << 12) | (((i >> 20) & 32'h1) << 11)
          | (((i >> 21) & 32'h3FF) << 1);
        if (u[20]) u = u - 32'h0020_0000;
      end
      32'h67, 32'h03, 32'h13: begin
        d.wr = 1'b1; d.rd1 = 1'b1;
        u = i >> 20;
        if (u[11]) u = u - 32'h1000;
        if ((i & 32'h7F) == 32'h13 && (f3 == 32'd1 || f3 == 32'd5)) d.alt = i[30];
      end
      32'h23: begin
        d.rd1 = 1'b1; d.rd2 = 1'b1;
        u = ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
        if (u[11]) u = u - 32'h1000;
      end
      32'h63: begin
        d.rd1 = 1'b1; d.rd2 = 1'b1;
        u = ((i >> 31) << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
          | (((i >> 8) & 32'hF) << 1);
        if (u[12]) u = u - 32'h2000;
      end
      32'h33: begin d.wr = 1'b1; d.rd1 = 1'b1; d.rd2 = 1'b1; d.alt = i[30]; end
      default: d.legal = 1'b0;
    endcase
    d.imm = u;
    if (i[11:7] == 5'd0) d.wr = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] mop(bit fwd, logic en, logic [4:0] a, logic [31:0] rf);
    if (!en || a == 5'd0) return 32'h0;
    if (fwd && ex_wreg && !ex_is_load && ex_wd == a) return ex_wdata;
    if (fwd && mem_wreg && mem_wd == a) return mem_wdata;
    return rf;
  endfunction

  function automatic bit mhaz(bit fwd, dec_t d, logic [4:0] s1, logic [4:0] s2);
    logic [4:0] srcs [2];
    logic       ens  [2];
    bit         h;
    srcs[0] = s1; srcs[1] = s2; ens[0] = d.rd1; ens[1] = d.rd2;
    h = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (ens[k] && srcs[k] != 5'd0) begin
        if (fwd) h = h | (ex_is_load && ex_wreg && ex_wd == srcs[k]);
        else     h = h | (ex_wreg && ex_wd == srcs[k]) | (mem_wreg && mem_wd == srcs[k]);
      end
    end
    return h;
  endfunction

  function automatic bundle_t mnext(bundle_t cur, bit fwd);
    dec_t    d;
    bundle_t n;
    d = mdec(inst);
    n = cur;
    if (flush) n.valid = 1'b0;
    else if (!cur.valid || ex_ready) begin
      n.valid  = if_valid && !mhaz(fwd, d, inst[19:15], inst[24:20]);
      n.aluop  = inst[14:12];
      n.alusel = inst[6:0];
      n.alt    = d.alt;
      n.r1     = mop(fwd, d.rd1, inst[19:15], reg1_data);
      n.r2     = mop(fwd, d.rd2, inst[24:20], reg2_data);
      n.imm    = d.imm;
      n.wd     = inst[11:7];
      n.wreg   = d.wr;
      n.ld     = (inst[6:0] == 7'h03);
      n.st     = (inst[6:0] == 7'h23);
      n.ill    = !d.legal;
      n.pc     = pc;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 = '0;
      m0 = '0;
    end else begin
      m1 = mnext(m1, 1'b1);
      m0 = mnext(m0, 1'b0);
    end
  end

  task automatic cmp_all(string t, bundle_t a, bundle_t m, bit fwd, logic rdy,
                         logic r1e, logic r2e, logic [4:0] ad1, logic [4:0] ad2);
    dec_t d;
    logic exp_rdy;
    d = mdec(inst);
    exp_rdy = flush | ((!m.valid | ex_ready) & !mhaz(fwd, d, inst[19:15], inst[24:20]));
    check({t, ".ex_valid"}, 32'(a.valid),  32'(m.valid));
    check({t, ".aluop"},    32'(a.aluop),  32'(m.aluop));
    check({t, ".alusel"},   32'(a.alusel), 32'(m.alusel));
    check({t, ".alu_alt"},  32'(a.alt),    32'(m.alt));
    check({t, ".reg1"},     a.r1,          m.r1);
    check({t, ".reg2"},     a.r2,          m.r2);
    check({t, ".imm"},      a.imm,         m.imm);
    check({t, ".wd"},       32'(a.wd),     32'(m.wd));
    check({t, ".wreg"},     32'(a.wreg),   32'(m.wreg));
    check({t, ".is_load"},  32'(a.ld),     32'(m.ld));
    check({t, ".is_store"}, 32'(a.st),     32'(m.st));
    check({t, ".illegal"},  32'(a.ill),    32'(m.ill));
    check({t, ".pc"},       a.pc,          m.pc);
    check({t, ".if_ready"}, 32'(rdy),      32'(exp_rdy));
    check({t, ".rd1_en"},   32'(r1e),      32'(d.rd1));
    check({t, ".rd2_en"},   32'(r2e),      32'(d.rd2));
    check({t, ".rd1_addr"}, 32'(ad1),      32'(inst[19:15]));
    check({t, ".rd2_addr"}, 32'(ad2),      32'(inst[24:20]));
  endtask

  always @(negedge clk) begin
    cmp_all("fwd1", a1, m1, 1'b1, if_ready1, rd1_1, rd2_1, ad1_1, ad2_1);
    cmp_all("fwd0", a0, m0, 1'b0, if_ready0, rd1_0, rd2_0, ad1_0, ad2_0);
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_wb();
    ex_wreg = 0; ex_is_load = 0; ex_wd = 0; ex_wdata = 0;
    mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
  endtask

  logic [31:0] extra [8];

  initial begin
    rst = 1; flush = 0; if_valid = 0; ex_ready = 1; pc = 0; inst = 0;
    reg1_data = 0; reg2_data = 0;
    clear_wb();
    cyc(2);
    check("rst.ex_valid", 32'(if1.ex_valid_o), 32'h0);
    check("rst.imm",      if1.imm_o,           32'h0);
    rst = 0;
    #1;
    check("rel.ex_valid", 32'(if1.ex_valid_o), 32'h0);
    check("rel.illegal",  32'(if1.illegal_o),  32'h0);
    check("rel.wreg",     32'(if1.wreg_o),     32'h0);
    check("rel.pc",       if1.pc_o,            32'h0);
    check("rel.reg1",     if1.reg1_o,          32'h0);

    // addi x3,x0,32
    inst = 32'h0200_0193; pc = 32'h100; if_valid = 1; reg1_data = 32'h10;
    cyc(1);
    check("addi.valid",  32'(if1.ex_valid_o), 32'h1);
    check("addi.reg1",   if1.reg1_o,          32'h0);
    check("addi.imm",    if1.imm_o,           32'h20);
    check("addi.wd",     32'(if1.wd_o),       32'h3);
    check("addi.wreg",   32'(if1.wreg_o),     32'h1);
    check("addi.aluop",  32'(if1.aluop_o),    32'h0);
    check("addi.alusel", 32'(if1.alusel_o),   32'h13);
    check("addi.rd2_en", 32'(rd2_1),          32'h0);

    // add x5,x1,x2: EX forwards rs1, MEM forwards rs2
    inst = 32'h0020_82B3; pc = 32'h104; reg1_data = 32'h11; reg2_data = 32'h22;
    ex_wreg = 1; ex_wd = 1; ex_wdata = 32'hAA;
    mem_wreg = 1; mem_wd = 2; mem_wdata = 32'hCC;
    #1;
    check("add.nofwd_stall", 32'(if_ready0), 32'h0);
    cyc(1);
    check("add.reg1_ex",   if1.reg1_o,          32'hAA);
    check("add.reg2_mem",  if1.reg2_o,          32'hCC);
    check("add.nofwd_bub", 32'(if0.ex_valid_o), 32'h0);
    ex_wreg = 0; mem_wd = 1; mem_wdata = 32'hBB;
    cyc(1);
    check("add.reg1_mem", if1.reg1_o, 32'hBB);
    check("add.reg2_rf",  if1.reg2_o, 32'h22);
    clear_wb();
    #1;
    check("add.nofwd_go", 32'(if_ready0), 32'h1);
    cyc(1);
    check("add.nofwd_valid", 32'(if0.ex_valid_o), 32'h1);
    check("add.nofwd_reg1",  if0.reg1_o,          32'h11);

    // load-use on x1
    ex_is_load = 1; ex_wreg = 1; ex_wd = 1; ex_wdata = 32'hDEAD;
    #1;
    check("lu.if_ready", 32'(if_ready1), 32'h0);
    cyc(1);
    check("lu.bubble", 32'(if1.ex_valid_o), 32'h0);
    clear_wb();
    mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h55;
    cyc(1);
    check("lu.issue", 32'(if1.ex_valid_o), 32'h1);
    check("lu.reg1",  if1.reg1_o,          32'h55);

    // back-pressure, including a hazard while held
    clear_wb();
    ex_ready = 0; inst = 32'h0200_0193; pc = 32'h108;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        inst = 32'hFE20_8CE3; ex_is_load = 1; ex_wreg = 1; ex_wd = 1;
      end
      #1;
      check("bp.if_ready", 32'(if_ready1), 32'h0);
      cyc(1);
      check("bp.valid",  32'(if1.ex_valid_o), 32'h1);
      check("bp.alusel", 32'(if1.alusel_o),   32'h33);
      check("bp.reg1",   if1.reg1_o,          32'h55);
    end
    flush = 1;
    #1;
    check("fl.if_ready", 32'(if_ready1), 32'h1);
    cyc(1);
    check("fl.valid", 32'(if1.ex_valid_o), 32'h0);
    flush = 0; ex_ready = 1;
    clear_wb();

    // beq x1,x2,-8
    inst = 32'hFE20_8CE3; pc = 32'h10C;
    #1;
    check("beq.rd1_en", 32'(rd1_1), 32'h1);
    check("beq.rd2_en", 32'(rd2_1), 32'h1);
    cyc(1);
    check("beq.imm",  if1.imm_o,          32'hFFFF_FFF8);
    check("beq.wreg", 32'(if1.wreg_o),    32'h0);
    check("beq.valid", 32'(if1.ex_valid_o), 32'h1);

    // opcode 0x7F, rd=3
    inst = 32'h0000_01FF; pc = 32'h110;
    #1;
    check("ill.rd1_en", 32'(rd1_1), 32'h0);
    cyc(1);
    check("ill.illegal", 32'(if1.illegal_o),  32'h1);
    check("ill.wreg",    32'(if1.wreg_o),     32'h0);
    check("ill.valid",   32'(if1.ex_valid_o), 32'h1);

    // lui, auipc, jal x0, sw, srai, sub, lw, jalr: model-checked only
    extra[0] = 32'h1234_52B7; extra[1] = 32'hFFFF_F317; extra[2] = 32'h0080_006F;
    extra[3] = 32'h0020_A223; extra[4] = 32'h4030_D093; extra[5] = 32'h4020_8233;
    extra[6] = 32'hFFC0_A303; extra[7] = 32'h0001_00E7;
    for (int k = 0; k < 8; k++) begin
      inst = extra[k]; pc = 32'h200 + 32'(k) * 4;
      reg1_data = 32'h1000 + 32'(k); reg2_data = 32'h2000 + 32'(k);
      if_valid = (k != 5);
      ex_ready = (k != 3);
      cyc(1);
    end
    if_valid = 1; ex_ready = 1;

    // async reset while stalled
    inst = 32'h0200_0193; pc = 32'h300;
    cyc(1);
    ex_ready = 0;
    cyc(2);
    check("rs.held", 32'(if1.ex_valid_o), 32'h1);
    rst = 1;
    #1;
    check("rs.valid1", 32'(if1.ex_valid_o), 32'h0);
    check("rs.valid0", 32'(if0.ex_valid_o), 32'h0);
    cyc(1);
    rst = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
